// File: rtl/a5_1_if.sv
// Key and keystream bundle between the A5/1 generator and its user.
interface a5_1_if;
  logic [0:63] secret;
  logic        init_ok;
  logic        ks;

  modport master (output secret, input init_ok, input ks);
  modport slave  (input secret, output init_ok, output ks);
endinterface

// File: rtl/a5_1_top.sv
// A5/1 keystream generator: key load, frame load, 100 discarded mixing
// clocks, then one keystream bit per clock from three majority-clocked LFSRs.
module a5_1_top #(
  parameter logic [21:0] FRAME = 22'h000000
) (
  input  logic clk,
  input  logic rst,
  a5_1_if.slave bus
);

  typedef enum logic [2:0] {IDLE, KEY, FRAMEP, MIX, RUN} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [18:0] r1;
  logic [21:0] r2;
  logic [22:0] r3;
  logic        init_ok_q;
  logic        step1, step2, step3;
  logic        in_bit;
  logic        maj;

  assign maj = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);

  // Phase sequencing and per-register step enables; load phases step all
  // three registers and inject one bit, later phases use majority clocking.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    step1    = 1'b0;
    step2    = 1'b0;
    step3    = 1'b0;
    in_bit   = 1'b0;
    case (state)
      IDLE: begin
        state_nx = KEY;
        cnt_nx   = 8'd0;
      end
      KEY: begin
        step1  = 1'b1;
        step2  = 1'b1;
        step3  = 1'b1;
        in_bit = bus.secret[cnt[5:0]];
        if (cnt == 8'd63) begin
          state_nx = FRAMEP;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      FRAMEP: begin
        step1  = 1'b1;
        step2  = 1'b1;
        step3  = 1'b1;
        in_bit = FRAME[cnt[4:0]];
        if (cnt == 8'd21) begin
          state_nx = MIX;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      MIX: begin
        step1 = (r1[8] == maj);
        step2 = (r2[10] == maj);
        step3 = (r3[10] == maj);
        if (cnt == 8'd99) begin
          state_nx = RUN;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      RUN: begin
        step1 = (r1[8] == maj);
        step2 = (r2[10] == maj);
        step3 = (r3[10] == maj);
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // FSM state, phase counter and the sticky init_ok flag (set on the first RUN step).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      init_ok_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      init_ok_q <= init_ok_q | (state == RUN);
    end
  end

  // LFSR shift with feedback XOR the load bit entering bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else begin
      if (step1) r1 <= {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ in_bit};
      if (step2) r2 <= {r2[20:0], r2[20] ^ r2[21] ^ in_bit};
      if (step3) r3 <= {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ in_bit};
    end
  end

  assign bus.init_ok = init_ok_q;
  assign bus.ks      = init_ok_q & (r1[18] ^ r2[21] ^ r3[22]);

endmodule

// File: tb/tb_a5_1_top.sv
// Bench for a5_1_top: two instances (FRAME=0 and FRAME=22'h000134) checked
// every cycle against a bit-level A5/1 model built from the register rules.
module tb_a5_1_top;

  localparam int KS_N = 260;
  localparam int RUN_EDGES = 188 + KS_N + 10;
  localparam logic [22:0] T1 = 23'h072000;
  localparam logic [22:0] T2 = 23'h300000;
  localparam logic [22:0] T3 = 23'h700080;

  logic clk;
  logic rst_n;

  a5_1_if bus0 ();
  a5_1_if bus1 ();

  a5_1_top #(.FRAME(22'h000000)) dut0 (.clk(clk), .rst(rst_n), .bus(bus0));
  a5_1_top #(.FRAME(22'h000134)) dut1 (.clk(clk), .rst(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt;
  int diff1;
  bit exp_ks [0:2][0:KS_N-1];
  logic [22:0] mk1, mk2, mk3;

  task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, expv, ecnt, $time);
    end
  endtask

  function automatic logic [22:0] lstep(input logic [22:0] r, input int len,
                                        input logic [22:0] taps, input logic b);
    logic [31:0] mm;
    logic [22:0] nv;
    mm = (32'h1 << len) - 32'h1;
    nv = {r[21:0], (^(r & taps)) ^ b};
    return nv & mm[22:0];
  endfunction

  function automatic logic majf(input logic a, input logic b, input logic c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  // Full A5/1 run from zeroed registers; fills exp_ks[sel] with the keystream.
  task automatic model_gen(input logic [0:63] key, input logic [21:0] fr, input int sel);
    logic [22:0] a, b, c;
    logic m;
    a = '0; b = '0; c = '0;
    for (int i = 0; i < 64; i++) begin
      a = lstep(a, 19, T1, key[i]);
      b = lstep(b, 22, T2, key[i]);
      c = lstep(c, 23, T3, key[i]);
    end
    mk1 = a; mk2 = b; mk3 = c;
    for (int j = 0; j < 22; j++) begin
      a = lstep(a, 19, T1, fr[j]);
      b = lstep(b, 22, T2, fr[j]);
      c = lstep(c, 23, T3, fr[j]);
    end
    for (int s = 0; s < 100 + KS_N; s++) begin
      m = majf(a[8], b[10], c[10]);
      if (a[8] == m)  a = lstep(a, 19, T1, 1'b0);
      if (b[10] == m) b = lstep(b, 22, T2, 1'b0);
      if (c[10] == m) c = lstep(c, 23, T3, 1'b0);
      if (s >= 100) exp_ks[sel][s-100] = a[18] ^ b[21] ^ c[22];
    end
  endtask

  // Edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  // Per-cycle compare: init_ok timing, keystream, majority-step invariant.
  logic [18:0] p1;
  logic [21:0] p2;
  logic [22:0] p3;
  int   pe;
  logic pv = 1'b0;

  always @(negedge clk) begin
    logic on;
    int   idx;
    logic m;
    logic [22:0] e1, e2, e3;
    on  = rst_n && (ecnt >= 188);
    idx = ecnt - 188;
    chk("init_ok0", {68'd0, bus0.init_ok}, {68'd0, on});
    chk("init_ok1", {68'd0, bus1.init_ok}, {68'd0, on});
    if (!on) begin
      chk("ks0_idle", {68'd0, bus0.ks}, 69'd0);
      chk("ks1_idle", {68'd0, bus1.ks}, 69'd0);
    end else if (idx < KS_N) begin
      chk("ks0", {68'd0, bus0.ks}, {68'd0, exp_ks[0][idx]});
      chk("ks1", {68'd0, bus1.ks}, {68'd0, exp_ks[1][idx]});
      if (idx < 64 && bus1.ks != exp_ks[2][idx]) diff1++;
    end
    if (rst_n && pv && ecnt == pe + 1) begin
      m  = majf(p1[8], p2[10], p3[10]);
      e1 = (p1[8] == m)  ? lstep({4'd0, p1}, 19, T1, 1'b0) : {4'd0, p1};
      e2 = (p2[10] == m) ? lstep({1'b0, p2}, 22, T2, 1'b0) : {1'b0, p2};
      e3 = (p3[10] == m) ? lstep(p3, 23, T3, 1'b0) : p3;
      chk("maj_step", {5'd0, dut0.r1, dut0.r2, dut0.r3}, {5'd0, e1[18:0], e2[21:0], e3});
    end
    pv = rst_n && bus0.init_ok;
    pe = ecnt;
    p1 = dut0.r1;
    p2 = dut0.r2;
    p3 = dut0.r3;
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_init_ok0", {68'd0, bus0.init_ok}, 69'd0);
    chk("rst_ks0",      {68'd0, bus0.ks},      69'd0);
    chk("rst_init_ok1", {68'd0, bus1.init_ok}, 69'd0);
    chk("rst_ks1",      {68'd0, bus1.ks},      69'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] k0;
    logic [63:0] k1;
    logic        any;
    rst_n = 1'b0;
    diff1 = 0;
    bus0.secret = '0;
    bus1.secret = 64'h0123456789ABCDEF;

    // Hand-derived pins on the model: only the last key bit set leaves 1 in
    // every register; the next-to-last leaves 2; an all-zero key gives zeros.
    model_gen(64'h1, 22'h0, 2);
    chk("pin_key_last_bit", {mk1, mk2, mk3}, {23'd1, 23'd1, 23'd1});
    model_gen(64'h2, 22'h0, 2);
    chk("pin_key_prev_bit", {mk1, mk2, mk3}, {23'd2, 23'd2, 23'd2});
    model_gen(64'h0, 22'h0, 0);
    any = 1'b0;
    for (int i = 0; i < KS_N; i++) any |= exp_ks[0][i];
    chk("pin_zero_stream", {68'd0, any}, 69'd0);

    // All-zero key on dut0; FRAME=22'h134 key on dut1, with its FRAME=0 twin.
    model_gen(64'h0123456789ABCDEF, 22'h000134, 1);
    model_gen(64'h0123456789ABCDEF, 22'h000000, 2);
    do_reset();
    repeat (RUN_EDGES) @(posedge clk);
    chk("frame_changes_ks", {68'd0, diff1 != 0}, 69'd1);

    // Golden key; secret changes after init_ok must not matter.
    bus0.secret = 64'h4E2F4D7C1EB88B3A;
    model_gen(64'h4E2F4D7C1EB88B3A, 22'h0, 0);
    do_reset();
    repeat (200) @(posedge clk);
    bus0.secret = {$urandom, $urandom};
    repeat (RUN_EDGES - 200) @(posedge clk);

    // Reset mid-MIX, then a full restart must reproduce the same keystream.
    bus0.secret = 64'h4E2F4D7C1EB88B3A;
    do_reset();
    repeat (120) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_init_ok", {68'd0, bus0.init_ok}, 69'd0);
    chk("midrst_ks",      {68'd0, bus0.ks},      69'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (RUN_EDGES) @(posedge clk);

    // Random keys on both instances.
    for (int t = 0; t < 2; t++) begin
      k0 = {$urandom, $urandom};
      k1 = {$urandom, $urandom};
      bus0.secret = k0;
      bus1.secret = k1;
      model_gen(k0, 22'h000000, 0);
      model_gen(k1, 22'h000134, 1);
      do_reset();
      repeat (RUN_EDGES) @(posedge clk);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
